// File: rtl/seg_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam int MAXD = 32;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} scan_state_t;

  // Callers zero-extend their image to MAXD digits so one helper serves any NDIG.
  function automatic logic [3:0] digit_slice(input logic [4*MAXD-1:0] data, input int i);
    return data[4*i +: 4];
  endfunction

endpackage

// File: rtl/bcd7seg.sv
// BCD/hex to 7-segment decoder, seg = {g,f,e,d,c,b,a}, active-high segments.
module bcd7seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b0000000;
    unique case (bcd)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed NDIG-digit 7-segment scanner with a double-buffered display image
// that is swapped only at frame boundaries (or at once while idle).
//
// state | meaning
// IDLE  | en low: counters held at 0, display dark, pending image commits immediately
// SCAN  | en high: dwell DIV cycles per digit, commit pending image at frame end
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int DIV  = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [4*NDIG-1:0] upd_data,
  input  logic [NDIG-1:0]   upd_blank,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic [3:0]        cur_bcd,
  output logic              frame_done
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  scan_state_t       state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic              pending_vld;
  logic [4*NDIG-1:0] pend_data;
  logic [NDIG-1:0]   pend_blank;
  logic [4*NDIG-1:0] active_data;
  logic [NDIG-1:0]   active_blank;

  logic       step, last_cnt, last_idx, boundary, commit, xfer, dark;
  logic [3:0] digit;
  logic [6:0] seg_dec;

  // A SCAN cycle with en already low is treated as the abort cycle, not a step.
  assign step     = (state == SCAN) && en;
  assign last_cnt = (cnt == CW'(DIV - 1));
  assign last_idx = (idx == IW'(NDIG - 1));
  assign boundary = step && last_cnt && last_idx;
  assign commit   = pending_vld && (boundary || (state == IDLE));
  assign xfer     = upd_valid && !pending_vld;
  assign upd_ready = !pending_vld;

  assign digit = digit_slice((4*MAXD)'(active_data), int'(idx));
  assign dark  = !step || active_blank[idx];

  bcd7seg u_dec (
    .bcd (digit),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      pending_vld  <= 1'b0;
      pend_data    <= '0;
      pend_blank   <= '0;
      active_data  <= '0;
      active_blank <= '1;
      seg          <= SEG_OFF;
      an           <= '1;
      cur_bcd      <= 4'h0;
      frame_done   <= 1'b0;
    end else begin
      state <= en ? SCAN : IDLE;

      if (step) begin
        if (last_cnt) begin
          cnt <= '0;
          idx <= last_idx ? '0 : idx + IW'(1);
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
        idx <= '0;
      end

      if (commit) begin
        active_data  <= pend_data;
        active_blank <= pend_blank;
        pending_vld  <= 1'b0;
      end
      if (xfer) begin
        pend_data   <= upd_data;
        pend_blank  <= upd_blank;
        pending_vld <= 1'b1;
      end

      cur_bcd    <= digit;
      an         <= dark ? '1 : ~(NDIG'(1) << idx);
      seg        <= dark ? SEG_OFF : seg_dec;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench: frame-position reference model plus directed literal pins and random traffic.
module tb_seg_scan_ctrl;

  localparam int NDIG = 4;
  localparam int DIV  = 4;
  localparam int FR   = NDIG * DIV;

  logic        clk = 1'b0;
  logic        rst_n, en, upd_valid, upd_ready, frame_done;
  logic [15:0] upd_data;
  logic [3:0]  upd_blank, an, cur_bcd;
  logic [6:0]  seg;

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_data   (upd_data),
    .upd_blank  (upd_blank),
    .seg        (seg),
    .an         (an),
    .cur_bcd    (cur_bcd),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int k;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Reference model: position within the frame as one integer, images as plain vectors.
  bit          m_scan = 0, m_pend = 0;
  int          pos = 0;
  logic [15:0] act_d = '0, pd = '0;
  logic [3:0]  act_b = '1, pb = '0;
  logic [6:0]  e_seg = '0;
  logic [3:0]  e_an = '1, e_cur = '0;
  logic        e_fd = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_scan = 0; m_pend = 0; pos = 0;
        act_d = '0; act_b = '1;
        e_seg = '0; e_an = '1; e_cur = '0; e_fd = 1'b0;
      end else begin
        bit stp, dark, cmt, xf;
        int dig;
        stp   = m_scan && en;
        dig   = pos / DIV;
        e_cur = act_d[dig*4 +: 4];
        dark  = !stp || act_b[dig];
        e_an  = dark ? 4'hF : ~(4'b0001 << dig);
        e_seg = dark ? 7'h00 : seg_of(e_cur);
        e_fd  = stp && (pos == FR - 1);
        cmt   = m_pend && ((stp && pos == FR - 1) || !m_scan);
        xf    = upd_valid && !m_pend;
        if (cmt) begin act_d = pd; act_b = pb; m_pend = 0; end
        if (xf)  begin pd = upd_data; pb = upd_blank; m_pend = 1; end
        pos    = stp ? (pos + 1) % FR : 0;
        m_scan = en;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_seg",   32'(seg),        32'(e_seg));
      chk("cmp_an",    32'(an),         32'(e_an));
      chk("cmp_cur",   32'(cur_bcd),    32'(e_cur));
      chk("cmp_fd",    32'(frame_done), 32'(e_fd));
      chk("cmp_ready", 32'(upd_ready),  32'(!m_pend));
    end
  end

  task automatic tick();
    @(negedge clk);
    k++;
  endtask

  task automatic go_to(input int t);
    while (k < t) tick();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; upd_valid = 1'b0; upd_data = '0; upd_blank = '0; k = 0;
    repeat (3) begin
      @(negedge clk);
      en = 1'($urandom); upd_valid = 1'($urandom);
      upd_data = 16'($urandom); upd_blank = 4'($urandom);
    end
    @(negedge clk);
    chk("rst_seg", 32'(seg), 32'h0);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_cur", 32'(cur_bcd), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
    chk("rst_ready", 32'(upd_ready), 32'h1);
    rst_n = 1'b1; en = 1'b0; upd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_an", 32'(an), 32'hF);
    chk("idle_seg", 32'(seg), 32'h0);

    // image load while idle
    upd_valid = 1'b1; upd_data = 16'h3210; upd_blank = 4'b0000;
    @(negedge clk);
    chk("load_ready_low", 32'(upd_ready), 32'h0);
    upd_valid = 1'b0;
    @(negedge clk);
    chk("load_ready_back", 32'(upd_ready), 32'h1);

    en = 1'b1; k = 0;
    go_to(1);  chk("first_dark", 32'(an), 32'hF);
    go_to(2);  chk("d0_an", 32'(an), 32'hE); chk("d0_seg", 32'(seg), 32'h3F); chk("d0_cur", 32'(cur_bcd), 32'h0);
    go_to(5);  chk("d0_hold", 32'(an), 32'hE);
    go_to(6);  chk("d1_an", 32'(an), 32'hD);
    go_to(10); chk("d2_an", 32'(an), 32'hB); chk("d2_cur", 32'(cur_bcd), 32'h2); chk("d2_seg", 32'(seg), 32'h5B);
    go_to(14); chk("d3_an", 32'(an), 32'h7); chk("d3_cur", 32'(cur_bcd), 32'h3);
    go_to(16); chk("fd_before", 32'(frame_done), 32'h0);
    go_to(17); chk("fd_pulse", 32'(frame_done), 32'h1);
    go_to(18); chk("fd_one_cycle", 32'(frame_done), 32'h0);
    go_to(33); chk("fd_next_frame", 32'(frame_done), 32'h1);

    // mid-frame update during digit 1
    go_to(38); upd_valid = 1'b1; upd_data = 16'h9876; upd_blank = 4'b0000;
    go_to(39); upd_valid = 1'b0;
    chk("mid_ready_low", 32'(upd_ready), 32'h0); chk("mid_old_d1", 32'(cur_bcd), 32'h1);
    go_to(48); chk("mid_ready_hold", 32'(upd_ready), 32'h0); chk("mid_old_d3", 32'(cur_bcd), 32'h3);
    go_to(49); chk("mid_ready_back", 32'(upd_ready), 32'h1); chk("mid_old_last", 32'(cur_bcd), 32'h3);
    go_to(50); chk("mid_new_d0", 32'(cur_bcd), 32'h6); chk("mid_new_an", 32'(an), 32'hE);

    // blank mask on digit 2
    upd_valid = 1'b1; upd_data = 16'h9876; upd_blank = 4'b0100;
    go_to(51); upd_valid = 1'b0;
    go_to(66); chk("blk_d0_cur", 32'(cur_bcd), 32'h6); chk("blk_d0_an", 32'(an), 32'hE);
    go_to(74); chk("blk_d2_an", 32'(an), 32'hF); chk("blk_d2_cur", 32'(cur_bcd), 32'h8);
    go_to(75); chk("blk_d2_seg", 32'(seg), 32'h0);
    go_to(78); chk("blk_d3_an", 32'(an), 32'h7); chk("blk_d3_seg", 32'(seg), 32'h6F);
    go_to(81); chk("blk_fd", 32'(frame_done), 32'h1);

    // enable drop at cnt=2, idx=2
    go_to(91); en = 1'b0;
    go_to(92); chk("drop_an", 32'(an), 32'hF); chk("drop_seg", 32'(seg), 32'h0); chk("drop_fd", 32'(frame_done), 32'h0);
    go_to(95); chk("drop_fd_later", 32'(frame_done), 32'h0);
    en = 1'b1; k = 0;
    go_to(2); chk("restart_d0", 32'(an), 32'hE);
    go_to(5); chk("restart_d0_full", 32'(an), 32'hE);
    go_to(6); chk("restart_d1", 32'(an), 32'hD);

    // async reset between edges with a pending image
    go_to(8);
    upd_valid = 1'b1; upd_data = 16'h4444; upd_blank = 4'b0000;
    @(posedge clk);
    #2;
    upd_valid = 1'b0;
    chk("pre_rst_pending", 32'(upd_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("arst_seg", 32'(seg), 32'h0);
    chk("arst_an", 32'(an), 32'hF);
    chk("arst_cur", 32'(cur_bcd), 32'h0);
    chk("arst_ready", 32'(upd_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_discarded", 32'(cur_bcd), 32'h0);

    // randomized traffic against the model
    repeat (900) begin
      @(negedge clk);
      if ($urandom_range(0, 40) == 0) en = ~en;
      upd_valid = ($urandom_range(0, 9) == 0);
      upd_data  = 16'($urandom);
      upd_blank = 4'($urandom);
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an NDIG-digit 7-segment display.
- One shared bcd7seg decoder serves all digits; the controller steps through the digits in turn and drives the digit selects.
- Upstream logic posts a full display image with a valid/ready handshake. The controller double-buffers it and swaps only at frame boundaries, so the display never shows a torn frame.

Parameters:
- NDIG, 4, number of digits scanned (>=1).
- DIV, 1000, clock cycles each digit is held (dwell) before advancing (>=1).
- IW, $clog2(NDIG) (min 1), width of the digit index; derived, not overridable.
- CW, $clog2(DIV) (min 1), width of the prescaler; derived, not overridable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; 0 = display dark.
- upd_valid  in  1  display image offered.
- upd_ready  out  1  controller can accept an image.
- upd_data  in  4*NDIG  BCD digits; digit i in bits [4i+3:4i].
- upd_blank  in  NDIG  per-digit blank mask; 1 = digit dark.
- seg  out  7  segment pattern from the shared decoder.
- an  out  NDIG  digit select, active-low one-hot.
- cur_bcd  out  4  BCD value currently being shown (debug/verification).
- frame_done  out  1  one-cycle pulse when the last digit's dwell ends.

Behaviour:
- Reset (async, rst_n=0):
  - cnt=0, idx=0, state=IDLE, pending_vld=0.
  - active_data=0, active_blank=all 1s.
  - Outputs: seg=0, an=all 1s, cur_bcd=0, frame_done=0, upd_ready=1.
- States:
  - IDLE (en=0): cnt=0, idx=0; an=all 1s, seg=0.
  - SCAN (en=1).
  - IDLE->SCAN on the first cycle en=1. SCAN->IDLE on the first cycle en=0.
  - Dropping en mid-frame aborts the frame: cnt and idx go to 0, no frame_done.
- Handshake:
  - upd_ready = ~pending_vld.
  - A transfer occurs on a cycle with upd_valid & upd_ready; the image is latched into the pending buffer and pending_vld is set next cycle.
  - upd_data and upd_blank are sampled only on a transfer.
- Commit (pending -> active):
  - SCAN: only on the boundary cycle (cnt==DIV-1 and idx==NDIG-1).
  - IDLE: on any cycle with pending_vld=1.
  - The commit clears pending_vld, so upd_ready=1 from the following cycle.
  - A transfer cannot coincide with a commit, since ready=0 whenever pending is full.
- Prescaler and digit index:
  - cnt increments every SCAN cycle. At DIV-1 it wraps to 0 and idx advances.
  - idx wraps from NDIG-1 to 0. On that wrap cycle frame_done is registered high for exactly one cycle.
  - DIV=1: idx advances every cycle. NDIG=1: frame_done every DIV cycles, and an stays 0 in SCAN.
- Output path (registered, 1-cycle latency from idx):
  - cur_bcd <= active_data[idx].
  - an <= ~(1<<idx), or all 1s if active_blank[idx] or IDLE.
  - seg <= bcd7seg(active_data[idx]), or 0 if blanked or IDLE.
  - A commit on the boundary cycle takes effect at digit 0 of the next frame.
- Arithmetic: cnt and idx compare against DIV-1 and NDIG-1 exactly; there is no out-of-range idx state. BCD values 10–15 are passed to the decoder unchanged.

Decomposition:
- Shared package (seg_pkg):
  - SEG_OFF = 7'b0000000.
  - Scan state enum {IDLE, SCAN}.
  - Helper function digit_slice(data, i).
- Sub-module: one bcd7seg instance (existing decoder, unmodified) fed from the idx mux. The prescaler stays inline; no other sub-module.

Test Plan (NDIG=4, DIV=4):
- Reset: hold rst_n=0 with random inputs -> seg=0, an=4'b1111, cur_bcd=0, frame_done=0, upd_ready=1; release -> outputs unchanged while en=0.
- IDLE load then scan: en=0, offer upd_data=16'h3210, blank=0 -> upd_ready falls for 1 cycle then returns 1. Raise en -> an sequence 1110,1101,1011,0111, 4 cycles each; cur_bcd 0,1,2,3; frame_done pulses every 16 cycles; seg matches the bcd7seg model.
- Mid-frame update: while showing digit 1, offer 16'h9876 -> accepted, upd_ready=0 until the boundary. Old digits are shown through digit 3, then cur_bcd=6 at the next digit 0, and upd_ready=1 the cycle after the commit.
- Blank mask: blank=4'b0100 -> during digit-2 dwell an=1111 and seg=0; other digits are normal; the frame still spans 16 cycles.
- en drop mid-frame: en=0 at cnt=2, idx=2 -> next cycle IDLE with dark outputs and no frame_done; re-raise en -> scan restarts at digit 0 with a full 4-cycle dwell.
- Async reset mid-scan: pulse rst_n low between clock edges with a pending image -> outputs return to reset values immediately, the pending image is discarded, and upd_ready=1.
